// File: rtl/pwm_slew_pkg.sv
// Shared types and defaults for the rate-limited duty slew stage and its
// tick generator.
package pwm_slew_pkg;
  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;
  localparam int STEP_W     = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } slew_state_e;

  // A programmed step of zero would stall a ramp forever, so it acts as one.
  function automatic logic [STEP_W-1:0] eff_step(input logic [STEP_W-1:0] s);
    return (s == '0) ? STEP_W'(1) : s;
  endfunction
endpackage

// File: rtl/slew_tick_gen.sv
// Programmable divider: one tick every (rate_div+1) counted cycles.
// Clear forces the count to zero; hold freezes it and masks the tick.
module slew_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_hold,
  input  logic [DIV_W-1:0] i_rate_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == i_rate_div);
  assign o_tick = w_wrap && !i_clear && !i_hold;

  always_ff @(posedge clk) begin
    if (rst || i_clear)
      r_cnt <= '0;
    else if (!i_hold)
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_duty_slew.sv
// Moves the PWM duty toward the requested target in bounded steps per tick,
// for soft-start/stop; bypass passes the target straight through.
module pwm_duty_slew
  import pwm_slew_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [STEP_W-1:0] step,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              enable,
  input  logic              bypass,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);
  localparam int DW1 = DUTY_W + 1;

  slew_state_e       r_state, w_state_nxt;
  logic [DUTY_W-1:0] r_duty, w_duty_nxt;
  logic              r_done, w_done_nxt;
  logic              w_tick, w_clear, w_hold;
  logic [DW1-1:0]    w_step, w_up_gap, w_dn_gap;

  assign w_clear = bypass || (r_state == IDLE);
  assign w_hold  = !enable;

  slew_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_hold    (w_hold),
    .i_rate_div(rate_div),
    .o_tick    (w_tick)
  );

  // One extra bit keeps the gap and the step sum free of wrap at either rail.
  assign w_step   = DW1'(eff_step(step));
  assign w_up_gap = {1'b0, target_duty} - {1'b0, r_duty};
  assign w_dn_gap = {1'b0, r_duty} - {1'b0, target_duty};

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_done_nxt  = 1'b0;
    if (bypass) begin
      w_state_nxt = IDLE;
      w_duty_nxt  = target_duty;
    end else if (enable) begin
      case (r_state)
        IDLE: begin
          if (target_duty > r_duty)      w_state_nxt = RAMP_UP;
          else if (target_duty < r_duty) w_state_nxt = RAMP_DOWN;
        end
        RAMP_UP: begin
          if (target_duty == r_duty) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (target_duty < r_duty) begin
            w_state_nxt = RAMP_DOWN;
          end else if (w_tick) begin
            if (w_up_gap <= w_step) begin
              w_duty_nxt  = target_duty;
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_duty_nxt = DUTY_W'({1'b0, r_duty} + w_step);
            end
          end
        end
        RAMP_DOWN: begin
          if (target_duty == r_duty) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (target_duty > r_duty) begin
            w_state_nxt = RAMP_UP;
          end else if (w_tick) begin
            if (w_dn_gap <= w_step) begin
              w_duty_nxt  = target_duty;
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_duty_nxt = DUTY_W'({1'b0, r_duty} - w_step);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_duty  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign duty_out = r_duty;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
endmodule

// File: tb/tb_pwm_duty_slew.sv
// Directed bench for pwm_duty_slew: an arithmetic reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_pwm_duty_slew;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  target_duty;
  logic [3:0]  step;
  logic [15:0] rate_div;
  logic        enable, bypass;
  logic [7:0]  duty_out;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_duty_slew #(.DUTY_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .target_duty(target_duty), .step(step),
    .rate_div(rate_div), .enable(enable), .bypass(bypass),
    .duty_out(duty_out), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: duty as an integer, direction as -1/0/+1, cycles since tick.
  int m_duty = 0, m_dir = 0, m_cnt = 0;
  bit m_done = 0, m_live = 0;

  always @(posedge clk) begin
    int gap, es;
    bit tk;
    m_live = 1;
    if (rst) begin
      m_duty = 0; m_dir = 0; m_cnt = 0; m_done = 0;
    end else if (bypass) begin
      m_duty = int'(target_duty); m_dir = 0; m_cnt = 0; m_done = 0;
    end else if (!enable) begin
      m_done = 0;
    end else begin
      m_done = 0;
      gap = int'(target_duty) - m_duty;
      es  = (step == 0) ? 1 : int'(step);
      if (m_dir == 0) begin
        m_cnt = 0;
        if (gap > 0) m_dir = 1;
        else if (gap < 0) m_dir = -1;
      end else begin
        tk = (m_cnt == int'(rate_div));
        m_cnt = tk ? 0 : m_cnt + 1;
        if (gap == 0) begin
          m_dir = 0; m_done = 1;
        end else if ((gap > 0) != (m_dir > 0)) begin
          m_dir = -m_dir;
        end else if (tk) begin
          if (gap * m_dir <= es) begin
            m_duty = int'(target_duty); m_dir = 0; m_done = 1;
          end else begin
            m_duty = m_duty + m_dir * es;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("mdl_duty", int'(duty_out), m_duty);
      chk("mdl_busy", int'(busy), (m_dir != 0) ? 1 : 0);
      chk("mdl_done", int'(done), int'(m_done));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_duty(input int v, input int lim, input string nm);
    int k = 0;
    while (int'(duty_out) != v && k < lim) begin nxt(); k++; end
    chk(nm, int'(duty_out), v);
  endtask

  task automatic wait_done(input int lim, input string nm);
    int k = 0;
    while (!done && k < lim) begin nxt(); k++; end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    rst = 1; target_duty = 8'hAA; step = 4'd3; rate_div = 16'd5;
    enable = 1; bypass = 0;
    nxt();
    chk("rst_duty", duty_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nxt();
    rst = 0; target_duty = 8'h00;
    nxt();
    chk("idle_busy", busy, 0);

    // basic ramp, step 4 every cycle
    target_duty = 8'h10; step = 4'd4; rate_div = 16'd0;
    nxt(); chk("up_enter_duty", duty_out, 8'h00); chk("up_enter_busy", busy, 1);
    nxt(); chk("up_d1", duty_out, 8'h04);
    nxt(); chk("up_d2", duty_out, 8'h08);
    nxt(); chk("up_d3", duty_out, 8'h0C); chk("up_d3_done", done, 0);
    nxt(); chk("up_d4", duty_out, 8'h10); chk("up_done", done, 1); chk("up_busy", busy, 0);
    nxt(); chk("up_done_off", done, 0);

    // clamp with a slow tick
    target_duty = 8'h13; step = 4'd8; rate_div = 16'd3;
    repeat (4) nxt();
    chk("clamp_hold", duty_out, 8'h10); chk("clamp_busy", busy, 1);
    nxt();
    chk("clamp_jump", duty_out, 8'h13); chk("clamp_done", done, 1); chk("clamp_idle", busy, 0);

    // reversal mid-ramp
    target_duty = 8'hFF; step = 4'd1; rate_div = 16'd3;
    wait_duty(8'h20, 200, "rev_reach20");
    target_duty = 8'h18;
    nxt(); chk("rev_turn_duty", duty_out, 8'h20); chk("rev_turn_busy", busy, 1);
    repeat (30) nxt();
    chk("rev_d19", duty_out, 8'h19);
    nxt();
    chk("rev_d18", duty_out, 8'h18); chk("rev_done", done, 1);

    // pause mid-ramp with step 0 acting as 1
    target_duty = 8'h30; step = 4'd0; rate_div = 16'd1;
    repeat (5) nxt();
    chk("pause_pre", duty_out, 8'h1A);
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("pause_duty", duty_out, 8'h1A);
      chk("pause_done", done, 0);
    end
    enable = 1;
    nxt(); chk("resume_d0", duty_out, 8'h1A);
    nxt(); chk("resume_d1", duty_out, 8'h1B);
    wait_done(100, "resume_done");
    chk("resume_final", duty_out, 8'h30);

    // reset mid-ramp
    target_duty = 8'h60; step = 4'd1; rate_div = 16'd0;
    repeat (8) nxt();
    chk("mid_pre", duty_out, 8'h37);
    rst = 1;
    nxt();
    chk("mid_rst_duty", duty_out, 8'h00); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    rst = 0;

    // bypass while ramping
    repeat (6) nxt();
    chk("byp_pre", duty_out, 8'h05); chk("byp_pre_busy", busy, 1);
    bypass = 1; target_duty = 8'hC0;
    nxt();
    chk("byp_duty", duty_out, 8'hC0); chk("byp_busy", busy, 0); chk("byp_done", done, 0);
    repeat (3) nxt();
    bypass = 0;
    nxt(); chk("byp_off_duty", duty_out, 8'hC0); chk("byp_off_busy", busy, 0);
    repeat (3) nxt();
    chk("byp_stay_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_duty_slew.md
Name: pwm_duty_slew

Overview:
- Rate-limited duty-cycle stage between the SPI register bank and the PWM generator.
- Takes the SPI-written target duty (8-bit) and moves the duty presented to the PWM generator toward it in programmable steps at a programmable tick rate.
- Purpose: soft-start and soft-stop of loads, with no abrupt duty jumps unless bypass is requested.

Parameters:
DUTY_W, 8, duty-cycle width (must match PWM generator input)
DIV_W, 16, width of tick-rate divider

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
target_duty  input  DUTY_W  requested duty from SPI register bank
step  input  4  increment per tick; 0 treated as 1
rate_div  input  DIV_W  tick period minus one, in clk cycles
enable  input  1  1 = slewing active; 0 = pause (hold all state)
bypass  input  1  1 = duty_out follows target_duty directly
duty_out  output  DUTY_W  duty to PWM generator, registered
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when a ramp lands on target

Behaviour:
- Single clock domain. All flops are reset synchronously on rst=1.
- Reset values: duty_out=0, busy=0, done=0, state=IDLE, tick counter=0.
- rst mid-ramp: on the next edge, duty_out=0 and state=IDLE. No done pulse.
- States: IDLE, RAMP_UP, RAMP_DOWN. busy is decoded from state (state != IDLE).
- Tick counter:
  - Cleared in IDLE.
  - In a RAMP state with enable=1: tick when counter==rate_div, then counter returns to 0; otherwise counter increments.
  - rate_div=0 gives a tick every cycle.
- IDLE transitions (enable=1, bypass=0):
  - target_duty > duty_out: go to RAMP_UP.
  - target_duty < duty_out: go to RAMP_DOWN.
  - Equal: stay in IDLE.
- Direction is re-evaluated every cycle while ramping:
  - Target crosses below duty_out in RAMP_UP: switch to RAMP_DOWN next edge.
  - Target crosses above duty_out in RAMP_DOWN: switch to RAMP_UP next edge.
  - Counter is not cleared on a direction change.
- Target becomes equal to duty_out while ramping: go to IDLE next edge and pulse done.
- On a tick, with eff_step = (step==0) ? 1 : step:
  - RAMP_UP: if target − duty_out ≤ eff_step, duty_out=target, done=1, go IDLE; else duty_out += eff_step.
  - RAMP_DOWN: mirror of RAMP_UP (clamp to target, otherwise subtract eff_step).
  - Arithmetic is done at DUTY_W+1 bits. The target clamp guarantees no wrap at 0 or 2^DUTY_W−1.
- Latency: target change sampled at edge N → state enters RAMP at N+1 → first duty_out change at edge N+2+rate_div.
- enable=0: duty_out, state and counter all hold. done is not pulsed. Resuming continues from the held counter value.
- bypass=1 (priority over enable and the ramp logic):
  - duty_out <= target_duty every edge.
  - State forced to IDLE, counter cleared, done=0.
- Simultaneous events: rst > bypass > enable=0 > ramp logic.
- done is registered and lasts exactly one cycle per completed ramp.

Decomposition:
- Shared package pwm_slew_pkg:
  - state enum {IDLE, RAMP_UP, RAMP_DOWN}
  - DUTY_W / DIV_W defaults
  - STEP_W=4
- One sub-module, slew_tick_gen:
  - Divider counter with clear and hold inputs and a tick output.
  - Reused by later rate-limited peripherals.

Test Plan:
- Reset: rst=1 with arbitrary inputs → duty_out=0x00, busy=0, done=0 after the first edge; the same holds when rst is asserted mid-ramp at duty_out=0x37.
- Basic ramp: target=0x10, step=4, rate_div=0, enable=1 → duty_out 0x04, 0x08, 0x0C, 0x10 on consecutive edges starting 2 edges after the target change; done pulses once with 0x10; busy falls the same edge.
- Clamp and slow rate: duty_out=0x10, target=0x13, step=8, rate_div=3 → duty_out holds 0x10 for 4 cycles, then jumps to 0x13 in a single step; done=1.
- Reversal: ramping toward 0xFF with step=1, rate_div=3; at duty_out=0x20 set target=0x18 → state becomes RAMP_DOWN next edge; duty_out decrements every 4 cycles to 0x18; then done.
- Pause and step=0: mid-ramp enable=0 for 10 cycles → duty_out constant, no done; re-enable → ramp resumes with step=0 behaving as 1.
- Bypass: duty_out=0x05 ramping, bypass=1, target=0xC0 → duty_out=0xC0 next edge, busy=0, done never asserted; bypass=0 with target unchanged → stays IDLE.
